bcrypt_key_storage: RTL and testbench

Key byte store feeding `bcrypt_expand_key_b`. Accepts plaintext key bytes from the word generator over a valid/ready byte stream and writes them into a RAM bank, followed by a 0x00 terminator. It then serves the bank to the expand-key reader through the `rd_addr`/`din`/`word_empty`/`word_set_empty` interface. With double buffering, the next key loads while the current one is being expanded.

---
 rtl/bcrypt_key_storage.sv | 123 ++++++++++++
 tb/tb_bcrypt_key_storage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcrypt_key_storage.sv
// Key byte store for bcrypt_expand_key_b: banked byte RAM loaded from a valid/ready stream, 0x00-terminated.
// Define BCRYPT_KEY_STORAGE_DOUBLE_BUF_EN for two banks (load next key while the current one is expanded).
module bcrypt_key_storage #(
  parameter int KEY_LEN = 72,
  localparam int AW = $clog2(KEY_LEN)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    din,
  output logic          word_empty,
  input  logic          word_set_empty,
  output logic          key_truncated
);

  // state   | meaning
  // WR_DATA | accepting key bytes into wr_bank
  // WR_TERM | writing 0x00 terminator, marking wr_bank full

`ifdef BCRYPT_KEY_STORAGE_DOUBLE_BUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int MW = $clog2(NBANK * KEY_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(KEY_LEN - 1);

  typedef enum logic {WR_DATA = 1'b0, WR_TERM = 1'b1} wr_state_t;

  wr_state_t     state, state_nxt;
  logic [AW-1:0] wr_idx;
  // Flags are sized for two banks; bank 1 stays idle in the single-bank build.
  logic [1:0]    full, full_nxt;
  logic [1:0]    trunc, trunc_nxt;
  logic          wr_bank, rd_bank;
  logic          accept, data_wr, term_wr, clr_full;
  logic [MW-1:0] wr_addr, rd_full_addr;
  logic [7:0]    mem [NBANK*KEY_LEN];

  assign accept   = in_valid & in_ready;
  assign data_wr  = accept & (wr_idx < LAST_IDX);
  assign term_wr  = (state == WR_TERM);
  assign clr_full = word_set_empty & full[rd_bank];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= WR_DATA;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WR_DATA: if (accept && in_last) state_nxt = WR_TERM;
      WR_TERM: state_nxt = WR_DATA;
      default: state_nxt = WR_DATA;
    endcase
  end

  always_comb begin
    in_ready = (state == WR_DATA) && !full[wr_bank];
  end

  // Clear is applied after set: same-bank collision (single-bank only) leaves the bank empty.
  always_comb begin
    full_nxt = full;
    if (term_wr)  full_nxt[wr_bank] = 1'b1;
    if (clr_full) full_nxt[rd_bank] = 1'b0;
  end

  always_comb begin
    trunc_nxt = trunc;
    if (accept) begin
      if (wr_idx == '0)       trunc_nxt[wr_bank] = 1'b0;
      if (wr_idx >= LAST_IDX) trunc_nxt[wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      full   <= '0;
      trunc  <= '0;
      wr_idx <= '0;
    end else begin
      full  <= full_nxt;
      trunc <= trunc_nxt;
      if (term_wr)      wr_idx <= '0;
      else if (data_wr) wr_idx <= wr_idx + 1'b1;
    end
  end

`ifdef BCRYPT_KEY_STORAGE_DOUBLE_BUF_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (term_wr)  wr_bank <= ~wr_bank;
      if (clr_full) rd_bank <= ~rd_bank;
    end
  end
`else
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
`endif

  assign wr_addr      = wr_bank ? MW'(KEY_LEN) + MW'(wr_idx)  : MW'(wr_idx);
  assign rd_full_addr = rd_bank ? MW'(KEY_LEN) + MW'(rd_addr) : MW'(rd_addr);

  // Key RAM is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (data_wr)      mem[wr_addr] <= in_byte;
    else if (term_wr) mem[wr_addr] <= 8'h00;
  end

  assign din           = mem[rd_full_addr];
  assign word_empty    = ~full[rd_bank];
  assign key_truncated = trunc[rd_bank];

endmodule

// File: tb/tb_bcrypt_key_storage.sv
// Self-checking bench for bcrypt_key_storage: random keys against a key-FIFO reference model.
module tb_bcrypt_key_storage;
  localparam int KEY_LEN = 72;
  localparam int AW = $clog2(KEY_LEN);
`ifdef BCRYPT_KEY_STORAGE_DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic          CLK, RST_N;
  logic [7:0]    in_byte;
  logic          in_valid, in_last, in_ready;
  logic [AW-1:0] rd_addr;
  logic [7:0]    din;
  logic          word_empty, word_set_empty, key_truncated;

  int n_checks = 0;
  int n_fail = 0;

  bcrypt_key_storage #(.KEY_LEN(KEY_LEN)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_byte(in_byte), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .rd_addr(rd_addr), .din(din),
    .word_empty(word_empty), .word_set_empty(word_set_empty),
    .key_truncated(key_truncated));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: FIFO of stored key images (at most NB held)
  logic [7:0] cur_key[$];
  logic [7:0] m_img [2][KEY_LEN];
  int         m_len [2];
  bit         m_trunc [2];
  int         m_head = 0;
  int         m_cnt = 0;

  function automatic void model_store();
    int n, l, slot;
    n = cur_key.size();
    l = (n < KEY_LEN - 1) ? n : KEY_LEN - 1;
    slot = (m_head + m_cnt) % 2;
    for (int i = 0; i < l; i++) m_img[slot][i] = cur_key[i];
    m_img[slot][l] = 8'h00;
    m_len[slot] = l + 1;
    m_trunc[slot] = (n > KEY_LEN - 1);
    m_cnt++;
  endfunction

  function automatic void model_release();
    if (m_cnt > 0) begin
      m_head = (m_head + 1) % 2;
      m_cnt--;
    end
  endfunction

  function automatic void model_clear();
    m_head = 0;
    m_cnt = 0;
  endfunction

  function automatic void random_key(input int len);
    cur_key.delete();
    for (int i = 0; i < len; i++)
      cur_key.push_back(($urandom_range(9, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1)));
  endfunction

  // All tasks start and end 1 time unit after a posedge.
  task automatic send_key(input int nbytes, input int gap_pct, output int cycles);
    int i, budget;
    bit acc;
    i = 0; cycles = 0; budget = 1000;
    while (i < nbytes && budget > 0) begin
      if ($urandom_range(99, 0) < gap_pct) begin
        in_valid = 1'b0; in_last = 1'b0;
      end else begin
        in_valid = 1'b1; in_byte = cur_key[i]; in_last = (i == cur_key.size() - 1);
      end
      @(negedge CLK);
      acc = in_valid & in_ready;
      @(posedge CLK); #1;
      cycles++; budget--;
      if (acc) i++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if (i < nbytes) begin
      n_fail++;
      $display("FAIL send_key timeout: sent %0d bytes, required %0d", i, nbytes);
    end
  endtask

  task automatic load_key(input int gap_pct);
    int cyc;
    send_key(cur_key.size(), gap_pct, cyc);
    @(posedge CLK); #1;
    model_store();
  endtask

  task automatic check_front(input string name);
    @(negedge CLK);
    n_checks++;
    if (word_empty !== (m_cnt == 0)) begin
      n_fail++;
      $display("FAIL %s word_empty: got %b, want %b", name, word_empty, (m_cnt == 0));
    end
    n_checks++;
    if (in_ready !== (m_cnt < NB)) begin
      n_fail++;
      $display("FAIL %s in_ready: got %b, want %b", name, in_ready, (m_cnt < NB));
    end
    if (m_cnt > 0) begin
      n_checks++;
      if (key_truncated !== m_trunc[m_head]) begin
        n_fail++;
        $display("FAIL %s key_truncated: got %b, want %b", name, key_truncated, m_trunc[m_head]);
      end
    end
    @(posedge CLK); #1;
    if (m_cnt > 0) begin
      for (int a = 0; a < m_len[m_head]; a++) begin
        rd_addr = AW'(a);
        @(negedge CLK);
        n_checks++;
        if (din !== m_img[m_head][a]) begin
          n_fail++;
          $display("FAIL %s din[%0d]: got %h, want %h", name, a, din, m_img[m_head][a]);
        end
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic release_bank();
    word_set_empty = 1'b1;
    @(posedge CLK); #1;
    word_set_empty = 1'b0;
    model_release();
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || word_empty !== 1'b1 || key_truncated !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got rdy=%b empty=%b trunc=%b, want 1 1 0", in_ready, word_empty, key_truncated);
    end
    RST_N = 1'b1;
    model_clear();
    @(posedge CLK); #1;
  endtask

  task automatic test_abc();
    int cyc;
    cur_key = '{8'h61, 8'h62, 8'h63};
    send_key(3, 0, cyc);
    n_checks++;
    if (cyc !== 3) begin
      n_fail++;
      $display("FAIL abc throughput: got %0d cycles, want 3", cyc);
    end
    @(negedge CLK);
    n_checks++;
    if (word_empty !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abc term cycle: got empty=%b rdy=%b, want 1 0", word_empty, in_ready);
    end
    @(posedge CLK); #1;
    model_store();
    check_front("abc");
    release_bank();
    check_front("abc_released");
  endtask

  task automatic test_truncation();
    cur_key.delete();
    for (int i = 0; i < 80; i++) cur_key.push_back(8'h41);
    load_key(0);
    check_front("trunc80");
    release_bank();
    cur_key = '{8'h78};
    load_key(0);
    check_front("after_trunc_x");
    release_bank();
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int k = 0; k < NB; k++) begin
      random_key($urandom_range(12, 1));
      load_key(0);
    end
    random_key($urandom_range(12, 2));
    in_valid = 1'b1; in_byte = cur_key[0]; in_last = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall: got in_ready=%b, want 0", in_ready);
    end
    @(posedge CLK); #1;
    check_front("b2b_first");
    release_bank();
    n_checks++;
    if (in_ready !== 1'b1 || word_empty !== (m_cnt == 0)) begin
      n_fail++;
      $display("FAIL release: got rdy=%b empty=%b, want 1 %b", in_ready, word_empty, (m_cnt == 0));
    end
    send_key(cur_key.size(), 0, cyc);
    n_checks++;
    if (cyc !== cur_key.size()) begin
      n_fail++;
      $display("FAIL resume: got %0d cycles, want %0d", cyc, cur_key.size());
    end
    @(posedge CLK); #1;
    model_store();
    while (m_cnt > 0) begin
      check_front("b2b_drain");
      release_bank();
    end
    check_front("b2b_empty");
  endtask

  task automatic test_empty_release();
    release_bank();
    release_bank();
    check_front("empty_release");
    cur_key = '{8'h71};
    load_key(0);
    check_front("empty_release_q");
    release_bank();
  endtask

  task automatic test_reset_mid();
    int cyc;
    random_key(10);
    send_key(5, 0, cyc);
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || word_empty !== 1'b1 || key_truncated !== 1'b0) begin
      n_fail++;
      $display("FAIL mid reset outputs: got rdy=%b empty=%b trunc=%b, want 1 1 0", in_ready, word_empty, key_truncated);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    model_clear();
    @(posedge CLK); #1;
    cur_key = '{8'h6B};
    load_key(0);
    check_front("reset_mid_k");
    release_bank();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      random_key($urandom_range(90, 1));
      load_key(30);
      check_front("random");
      release_bank();
    end
  endtask

  task automatic test_expand();
    int ptr, p;
    logic [31:0] word, exp_word;
    logic [7:0] b;
    cur_key = '{8'h61, 8'h62};
    load_key(0);
    ptr = 0; p = 0;
    for (int w = 0; w < 18; w++) begin
      word = '0; exp_word = '0;
      for (int k = 0; k < 4; k++) begin
        rd_addr = AW'(ptr);
        @(negedge CLK);
        b = din;
        word = {word[23:0], b};
        exp_word = {exp_word[23:0], m_img[m_head][p % m_len[m_head]]};
        p++;
        @(posedge CLK); #1;
        ptr = (b == 8'h00 || ptr >= KEY_LEN - 1) ? 0 : ptr + 1;
      end
      n_checks++;
      if (word !== exp_word) begin
        n_fail++;
        $display("FAIL expand word %0d: got %h, want %h", w, word, exp_word);
      end
    end
    release_bank();
    check_front("expand_released");
  endtask

  initial begin
    RST_N = 1'b0; in_byte = '0; in_valid = 1'b0; in_last = 1'b0;
    rd_addr = '0; word_set_empty = 1'b0;
    #1;
    test_reset();
    test_abc();
    test_truncation();
    test_back_to_back();
    test_empty_release();
    test_reset_mid();
    test_random();
    test_expand();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
